if_pc_gen: RTL

- Instruction-fetch PC generator and fetch controller; the producer end of the IF→ID path.
- Owns the program counter and drives the instruction ROM address.
- Drives inst_addr, pipeline_flush and pipeline_stall into the IF/ID buffer.
- Handles sequential fetch, branch/jump redirect, hazard stall, ROM wait-states, a post-reset boot delay and a debug halt.

---
 rtl/if_pc_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen : instruction-fetch PC generator and fetch controller.
//
// Owns the program counter and drives the instruction ROM address. It handles
// sequential fetch, branch/jump redirect, hazard stall, ROM wait-states, a
// post-reset boot delay and a debug halt. It also drives flush/stall into the
// IF/ID buffer.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   jump_en_i           redirect request from EX (branch taken / jal / jalr)
//   jump_addr_i         redirect target (low two bits are dropped)
//   stall_i             hazard-unit stall request
//   halt_i              debug halt request (level)
//   resume_i            debug resume pulse
//   rom_ready_i         ROM data for rom_addr_o is valid this cycle
//   rom_req_o           fetch request to ROM
//   rom_addr_o          fetch address (= pc_q)
//   inst_addr_o         address to IF/ID buffer (= pc_q)
//   pipeline_flush_o    flush to IF/ID buffer
//   pipeline_stall_o    stall to IF/ID buffer
//   addr_misalign_o     one-cycle pulse: last taken redirect target was misaligned
//   halted_o            controller is in debug halt
// -----------------------------------------------------------------------------
module if_pc_gen #(
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    RST_ADDR    = '0,
  parameter int unsigned          BOOT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              rom_ready_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              pipeline_flush_o,
  output logic              pipeline_stall_o,
  output logic              addr_misalign_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [3:0]        BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [3:0]          boot_cnt_q, boot_cnt_d;
  logic                misalign_q, misalign_d;

  logic                rom_req_s;
  logic                stall_s;
  logic                flush_s;
  logic [ADDR_W-1:0]   jump_tgt_s;
  logic                jump_misalign_s;

  assign jump_tgt_s      = {jump_addr_i[ADDR_W-1:2], 2'b00};
  assign jump_misalign_s = |jump_addr_i[1:0];

  // Next-state, next-PC and IF/ID control computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    misalign_d = 1'b0;
    rom_req_s  = 1'b0;
    stall_s    = 1'b1;
    flush_s    = 1'b1;

    case (state_q)
      ST_BOOT: begin
        // Redirect, stall and halt requests are ignored while booting.
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = 4'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_RUN: begin
        rom_req_s = 1'b1;
        // Stall is reported even alongside a redirect; IF/ID lets flush win.
        stall_s   = stall_i | ~rom_ready_i;
        flush_s   = jump_en_i;
        if (jump_en_i) begin
          pc_d       = jump_tgt_s;
          misalign_d = jump_misalign_s;
          if (halt_i) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (stall_i || !rom_ready_i) begin
          pc_d = pc_q;
        end else begin
          // Natural wrap modulo 2^ADDR_W.
          pc_d = pc_q + PC_STEP;
        end
      end

      ST_HALT: begin
        flush_s = jump_en_i;
        // A redirect while halted still updates the PC; fetch resumes there.
        if (jump_en_i) begin
          pc_d       = jump_tgt_s;
          misalign_d = jump_misalign_s;
        end else begin
          pc_d = pc_q;
        end
        if (resume_i && !halt_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d    = ST_BOOT;
        pc_d       = RST_ADDR;
        boot_cnt_d = 4'd0;
      end
    endcase
  end

  // State, PC, boot counter and misalign pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RST_ADDR;
      boot_cnt_q <= 4'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // While reset is held the fetch side is quiesced regardless of state.
  assign rom_req_o        = rst_n & rom_req_s;
  assign pipeline_stall_o = ~rst_n | stall_s;
  assign pipeline_flush_o = ~rst_n | flush_s;

  // Addresses come straight from the PC register, so rom_ready_i never
  // reaches them combinationally.
  assign rom_addr_o       = pc_q;
  assign inst_addr_o      = pc_q;
  assign addr_misalign_o  = misalign_q;
  assign halted_o         = (state_q == ST_HALT);

endmodule
